// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequencing controller for the ID/EX pipeline register and its neighbours.
//   Drives the global cpu_en, the ID/EX bubble request and the PC / IF/ID
//   hold and flush controls. It also provides a post-reset hold and a debug
//   halt/single-step mode.
//   Optional build macro: HAZARD_PERF_COUNTERS_EN adds three wrapping
//   performance counters (enabled cycles, load-use stalls, branch flushes).

module pipeline_hazard_controller #(
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int CNT_WIDTH         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_mode,
    input  logic       step_req,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_registerWriteAddress,
    input  logic       ex_ifWriteRegsFile,
    input  logic       ex_memOutOrAluOutWriteBackToRegFile,
    input  logic       ex_shouldJumpOrBranch,
    output logic       cpu_en,
    output logic       id_shouldStall,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_cycles,
    output logic [CNT_WIDTH-1:0] perf_load_stalls,
    output logic [CNT_WIDTH-1:0] perf_branch_flushes
`endif
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } stateT;

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    stateT             state;
    logic [HOLD_W-1:0] holdCnt;
    logic              stepReqPrev;
    logic              stepEdge;
    logic              loadUse;

    // Only a fresh 0->1 transition of step_req requests a step, so a held
    // level yields a single step.
    assign stepEdge   = step_req && !stepReqPrev;
    assign ctrl_state = state;

    // Sequencing FSM: post-reset hold, free run, debug halt and single step.
    // cpu_en is registered together with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HOLD;
            holdCnt     <= '0;
            stepReqPrev <= 1'b0;
            cpu_en      <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            stepReqPrev <= step_req;
            unique case (state)
                HOLD: begin
                    if (holdCnt == HOLD_LAST) begin
                        holdCnt <= '0;
                        if (run_mode) begin
                            state  <= RUN;
                            cpu_en <= 1'b1;
                        end else begin
                            state  <= HALT;
                            cpu_en <= 1'b0;
                        end
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!run_mode) begin
                        state  <= HALT;
                        cpu_en <= 1'b0;
                    end
                end
                HALT: begin
                    // Leaving debug mode takes priority over a step request.
                    if (run_mode) begin
                        state  <= RUN;
                        cpu_en <= 1'b1;
                    end else if (stepEdge) begin
                        state  <= STEP;
                        cpu_en <= 1'b1;
                    end
                end
                STEP: begin
                    if (run_mode) begin
                        state  <= RUN;
                        cpu_en <= 1'b1;
                    end else begin
                        state  <= HALT;
                        cpu_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Load-use hazard: a load in EX writes a non-zero register that the
    // instruction in ID reads. One bubble is enough because the bubble itself
    // moves the load out of EX.
    assign loadUse = ex_memOutOrAluOutWriteBackToRegFile && ex_ifWriteRegsFile &&
                     (ex_registerWriteAddress != 5'd0) &&
                     ((id_uses_rs && (id_rs_addr == ex_registerWriteAddress)) ||
                      (id_uses_rt && (id_rt_addr == ex_registerWriteAddress)));

    // Hazard response, gated by cpu_en; a taken branch overrides a load-use
    // hold so the PC can load the branch target.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        id_shouldStall = 1'b0;
        pc_hold        = 1'b0;
        if_id_hold     = 1'b0;
        if_id_flush    = 1'b0;
        if (cpu_en) begin
            if (ex_shouldJumpOrBranch) begin
                id_shouldStall = 1'b1;
                if_id_flush    = 1'b1;
            end else if (loadUse) begin
                id_shouldStall = 1'b1;
                pc_hold        = 1'b1;
                if_id_hold     = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    // Performance counters; all wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles         <= '0;
            perf_load_stalls    <= '0;
            perf_branch_flushes <= '0;
        end else begin
            if (cpu_en)      perf_cycles         <= perf_cycles + 1'b1;
            if (pc_hold)     perf_load_stalls    <= perf_load_stalls + 1'b1;
            if (if_id_flush) perf_branch_flushes <= perf_branch_flushes + 1'b1;
        end
    end
`else
    // Counters are absent in this build; CNT_WIDTH is intentionally unused.
    logic unusedCntWidth;
    assign unusedCntWidth = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
//   Scoreboard bench: each stimulus cycle pushes its expected output vector,
//   which is popped and compared once the DUT has clocked.
//   With HAZARD_PERF_COUNTERS_EN defined the counters are also checked.

module tb_pipeline_hazard_controller;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_mode;
    logic       step_req;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_registerWriteAddress;
    logic       ex_ifWriteRegsFile;
    logic       ex_memOutOrAluOutWriteBackToRegFile;
    logic       ex_shouldJumpOrBranch;
    logic       cpu_en;
    logic       id_shouldStall;
    logic       pc_hold;
    logic       if_id_hold;
    logic       if_id_flush;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [3:0] perf_cycles;
    logic [3:0] perf_load_stalls;
    logic [3:0] perf_branch_flushes;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [6:0] outs;
    } expT;

    expT expQ[$];

    logic [6:0] obsVec;
    assign obsVec = {cpu_en, id_shouldStall, pc_hold, if_id_hold, if_id_flush, ctrl_state};

    pipeline_hazard_controller #(
        .RESET_HOLD_CYCLES(4),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run_mode(run_mode),
        .step_req(step_req),
        .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .ex_registerWriteAddress(ex_registerWriteAddress),
        .ex_ifWriteRegsFile(ex_ifWriteRegsFile),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_memOutOrAluOutWriteBackToRegFile),
        .ex_shouldJumpOrBranch(ex_shouldJumpOrBranch),
        .cpu_en(cpu_en),
        .id_shouldStall(id_shouldStall),
        .pc_hold(pc_hold),
        .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush),
        .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_load_stalls(perf_load_stalls),
        .perf_branch_flushes(perf_branch_flushes)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] mk(input logic en, input logic st, input logic ph,
                                      input logic ih, input logic fl, input logic [1:0] s);
        return {en, st, ph, ih, fl, s};
    endfunction

    task automatic setHaz(input logic [4:0] rsA, input logic [4:0] rtA, input logic usesRs,
                          input logic usesRt, input logic [4:0] exA, input logic exW,
                          input logic exLd, input logic br);
        id_rs_addr                          = rsA;
        id_rt_addr                          = rtA;
        id_uses_rs                          = usesRs;
        id_uses_rt                          = usesRt;
        ex_registerWriteAddress             = exA;
        ex_ifWriteRegsFile                  = exW;
        ex_memOutOrAluOutWriteBackToRegFile = exLd;
        ex_shouldJumpOrBranch               = br;
    endtask

    task automatic clearHaz();
        setHaz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expected outputs for the next edge, clock once, then pop and
    // compare well after the edge.
    task automatic cycleStep(input string tag, input logic [6:0] e);
        expT item;
        item.tag  = tag;
        item.outs = e;
        expQ.push_back(item);
        @(posedge clk);
        #1;
        item = expQ.pop_front();
        check(item.tag, {25'd0, obsVec}, {25'd0, item.outs});
    endtask

    initial begin
        rst      = 1'b0;
        run_mode = 1'b1;
        step_req = 1'b0;
        clearHaz();

        #12;
        check("reset_state", {25'd0, obsVec}, 32'd0);

        // Post-reset hold; a pending load-use must stay masked until RUN.
        @(negedge clk);
        rst = 1'b1;
        setHaz(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++)
            cycleStep($sformatf("hold%0d", i), mk(0, 0, 0, 0, 0, S_HOLD));
        cycleStep("hold_exit_loaduse_rt5", mk(1, 1, 1, 1, 0, S_RUN));

        clearHaz();
        cycleStep("run_idle", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        cycleStep("loaduse_r0", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        cycleStep("load_nowrite", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cycleStep("alu_no_stall", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        cycleStep("rs_not_used", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        cycleStep("loaduse_rs7", mk(1, 1, 1, 1, 0, S_RUN));

        clearHaz();
        cycleStep("bubble_clears", mk(1, 0, 0, 0, 0, S_RUN));

        setHaz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycleStep("branch_only", mk(1, 1, 0, 0, 1, S_RUN));

        setHaz(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        cycleStep("branch_beats_loaduse", mk(1, 1, 0, 0, 1, S_RUN));

        // Halt with a branch still presented: everything gated off.
        run_mode = 1'b0;
        cycleStep("halt_gated", mk(0, 0, 0, 0, 0, S_HALT));
        clearHaz();
        cycleStep("halt_idle", mk(0, 0, 0, 0, 0, S_HALT));

        // step_req held high for five cycles gives exactly one step.
        step_req = 1'b1;
        cycleStep("step_on", mk(1, 0, 0, 0, 0, S_STEP));
        for (int i = 2; i <= 5; i++)
            cycleStep($sformatf("step_held%0d", i), mk(0, 0, 0, 0, 0, S_HALT));

        step_req = 1'b0;
        cycleStep("halt_step_low", mk(0, 0, 0, 0, 0, S_HALT));

        step_req = 1'b1;
        run_mode = 1'b1;
        cycleStep("run_beats_step", mk(1, 0, 0, 0, 0, S_RUN));

        run_mode = 1'b0;
        cycleStep("halt_again", mk(0, 0, 0, 0, 0, S_HALT));
        step_req = 1'b0;
        cycleStep("halt_rearm", mk(0, 0, 0, 0, 0, S_HALT));
        step_req = 1'b1;
        cycleStep("step_again", mk(1, 0, 0, 0, 0, S_STEP));

        // Asynchronous reset between edges while in STEP.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {25'd0, obsVec}, 32'd0);
        run_mode = 1'b1;
        step_req = 1'b0;
        cycleStep("in_reset1", mk(0, 0, 0, 0, 0, S_HOLD));
        cycleStep("in_reset2", mk(0, 0, 0, 0, 0, S_HOLD));

        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++)
            cycleStep($sformatf("rehold%0d", i), mk(0, 0, 0, 0, 0, S_HOLD));
        cycleStep("rehold_exit", mk(1, 0, 0, 0, 0, S_RUN));

        // Two load-use stall cycles, one flush cycle, then idle run:
        // 17 enabled cycles in total are counted by the check below.
        setHaz(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        cycleStep("perf_ld1", mk(1, 1, 1, 1, 0, S_RUN));
        cycleStep("perf_ld2", mk(1, 1, 1, 1, 0, S_RUN));
        setHaz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycleStep("perf_br", mk(1, 1, 0, 0, 1, S_RUN));
        clearHaz();
        for (int i = 1; i <= 14; i++)
            cycleStep($sformatf("perf_idle%0d", i), mk(1, 0, 0, 0, 0, S_RUN));

`ifdef HAZARD_PERF_COUNTERS_EN
        check("perf_cycles_wrap", {28'd0, perf_cycles}, 32'd1);
        check("perf_load_stalls", {28'd0, perf_load_stalls}, 32'd2);
        check("perf_branch_flushes", {28'd0, perf_branch_flushes}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencing controller for the ID/EX pipeline register and its neighbours. It generates the global cpu_en, the ID/EX bubble request (id_shouldStall), and the PC and IF/ID hold/flush controls. It detects load-use hazards and taken jumps/branches resolved in EX, and provides a post-reset hold plus a debug halt/single-step mode. It sits beside the ID stage and drives all pipeline-register enables.

Parameters:
RESET_HOLD_CYCLES, 4, cycles cpu_en stays low after reset release (>=1)
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
run_mode  in  1  1 = free run, 0 = debug halt/step
step_req  in  1  level; a 0->1 edge requests one step while halted
id_rs_addr  in  5  rs field of instruction in ID
id_rt_addr  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_registerWriteAddress  in  5  destination register of instruction in EX
ex_ifWriteRegsFile  in  1  EX instruction writes the register file
ex_memOutOrAluOutWriteBackToRegFile  in  1  1 = EX instruction is a load
ex_shouldJumpOrBranch  in  1  taken jump/branch resolved in EX
cpu_en  out  1  global pipeline advance enable
id_shouldStall  out  1  insert bubble into ID/EX
pc_hold  out  1  PC keeps its value
if_id_hold  out  1  IF/ID keeps its value
if_id_flush  out  1  IF/ID cleared to NOP
ctrl_state  out  2  current FSM state encoding

Behaviour:
- FSM states: HOLD=0, RUN=1, HALT=2, STEP=3. Asynchronous reset (rst=0) forces HOLD, clears hold counter and step edge register, and drives all outputs 0.
- HOLD: counter counts cycles after rst deasserts. After RESET_HOLD_CYCLES cycles go to RUN if run_mode=1, else HALT. cpu_en=0 throughout.
- RUN: cpu_en=1. If run_mode=0, go to HALT on the next edge. The instruction in flight completes its current cycle.
- HALT: cpu_en=0. A registered 0->1 edge on step_req goes to STEP. run_mode=1 goes to RUN; run_mode has priority over a simultaneous step edge.
- STEP: cpu_en=1 for exactly one cycle, then HALT (or RUN if run_mode=1). A step_req held high produces only one step.
- Hazard logic is combinational from inputs and is gated by cpu_en. When cpu_en=0, id_shouldStall, pc_hold, if_id_hold and if_id_flush are all 0.
- Load-use condition:
  - ex_memOutOrAluOutWriteBackToRegFile=1, ex_ifWriteRegsFile=1 and ex_registerWriteAddress!=0, and
  - (id_uses_rs and id_rs_addr==ex_registerWriteAddress) or (id_uses_rt and id_rt_addr==ex_registerWriteAddress).
  - Response: id_shouldStall=1, pc_hold=1, if_id_hold=1, if_id_flush=0.
- Taken branch: ex_shouldJumpOrBranch=1 gives if_id_flush=1 and id_shouldStall=1, with pc_hold=0 and if_id_hold=0 so the PC loads the target.
- A branch and a load-use in the same cycle: the branch wins; hold outputs are 0.
- Register 0 never causes a stall.
- A load-use stall lasts one cycle naturally, because the bubble removes the load from EX. No FSM state is needed for it.
- Outputs hold/flush/stall are never 1 while state is HOLD or HALT.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- When defined, add outputs:
  - perf_cycles[CNT_WIDTH]: counts cycles with cpu_en=1.
  - perf_load_stalls[CNT_WIDTH]: counts load-use stall cycles.
  - perf_branch_flushes[CNT_WIDTH]: counts flush cycles.
- All three counters wrap modulo 2^CNT_WIDTH and reset asynchronously to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset with run_mode=1, release rst at cycle 0 -> cpu_en=0 for cycles 0..3, cpu_en=1 from cycle 4, ctrl_state=1.
- RUN, EX = load to r5 (write=1), ID uses_rt=1 with rt=5 -> id_shouldStall=pc_hold=if_id_hold=1 for one cycle. Same case with destination r0 -> all 0.
- RUN, ex_shouldJumpOrBranch=1 together with a load-use match on rs=7 -> if_id_flush=1, id_shouldStall=1, pc_hold=0, if_id_hold=0.
- run_mode=0 -> HALT with cpu_en=0. Then step_req held high for 5 cycles -> exactly one cpu_en=1 cycle, back to HALT (state 2).
- Assert rst=0 asynchronously mid-STEP (between clock edges) -> all outputs 0 immediately and ctrl_state=0. After release, the full hold sequence repeats.
- With HAZARD_PERF_COUNTERS_EN and CNT_WIDTH=4: 17 enabled cycles -> perf_cycles=1 (wrap). 2 load stalls and 1 flush -> perf_load_stalls=2 and perf_branch_flushes=1.
